// File: rtl/shamt_shift_unit.sv
// Multi-cycle shift unit: narrows a zero-extended shift amount to 5 bits and shifts one bit per clock.
// Optional rotate (op 11) is built only when SHAMT_ROR_EN is defined; otherwise op 11 is flagged illegal.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | working register shifts one position per edge, counter counts down
// DONE  | result/range_err held, out_valid high until out_ready
module shamt_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] extShamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             range_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d;

  logic             oor;
  logic [4:0]       n;
  logic             illegal_op;

  assign oor = |extShamt[WIDTH-1:5];
  assign n   = extShamt[4:0];

`ifdef SHAMT_ROR_EN
  assign illegal_op = 1'b0;
`else
  assign illegal_op = (op == OP_ROR);
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          work_d = data;
          cnt_d  = n;
          err_d  = oor;
          if (illegal_op) begin
            err_d   = 1'b1;
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end else if (oor && (op != OP_ROR)) begin
            // Saturate: logical shifts clear, arithmetic shift fills with the sign
            work_d  = (op == OP_SRA) ? {WIDTH{data[WIDTH-1]}} : '0;
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end else if (n == 5'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
          OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
          OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHAMT_ROR_EN
          OP_ROR:  work_d = {work_q[0], work_q[WIDTH-1:1]};
`endif
          default: work_d = work_q;
        endcase
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= 5'd0;
      op_q    <= OP_SLL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = work_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_shamt_shift_unit.sv
// Self-checking bench for shamt_shift_unit: directed cases plus random requests against
// an arithmetic reference model; honours SHAMT_ROR_EN the same way the design does.
module tb_shamt_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data = '0;
  logic [31:0] extShamt = '0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        range_err;

  int errors = 0;
  int checks = 0;

`ifdef SHAMT_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  shamt_shift_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .extShamt  (extShamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the operation means, not how the unit steps through it
  task automatic model(input logic [31:0] d, input logic [31:0] s, input logic [1:0] o,
                       output logic [31:0] r, output logic e, output int lat);
    int  amt;
    bit  out_of_range;
    amt = int'(s % 32);
    out_of_range = (s > 32'd31);
    e   = out_of_range;
    lat = (amt == 0) ? 1 : amt + 1;
    case (o)
      2'b00: r = out_of_range ? 32'd0 : d << amt;
      2'b01: r = out_of_range ? 32'd0 : d >> amt;
      2'b10: r = out_of_range ? {32{d[31]}} : 32'($signed(d) >>> amt);
      default: begin
        if (ROR_EN) begin
          r = (amt == 0) ? d : ((d >> amt) | (d << (32 - amt)));
        end else begin
          r = d; e = 1'b1; lat = 1;
        end
      end
    endcase
    if (out_of_range && o != 2'b11) lat = 1;
  endtask

  task automatic req(input string tag, input logic [31:0] d, input logic [31:0] s,
                     input logic [1:0] o, input int hold);
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          k;
    int          w;
    logic [31:0] held;
    model(d, s, o, exp_r, exp_e, exp_lat);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; data = d; extShamt = s; op = o; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; data = $urandom; extShamt = $urandom; op = 2'($urandom);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".latency"}, 32'(k), 32'(exp_lat));
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".range_err"}, 32'(range_err), 32'(exp_e));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      data = $urandom;
      @(negedge clk);
      chk({tag, ".hold_result"}, result, held);
      chk({tag, ".hold_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_hs"}, {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    chk({tag, ".single_hs"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    logic [31:0] rs;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.range_err", 32'(range_err), 32'd0);
    rst_n = 1'b1;

    req("sll5",     32'h0000_0001, 32'd5,          2'b00, 0);
    req("sra31",    32'h8000_0000, 32'd31,         2'b10, 0);
    req("sra0",     32'h8000_0000, 32'd0,          2'b10, 0);
    req("oor_srl",  32'h1234_5678, 32'h0000_0020,  2'b01, 0);
    req("oor_sra",  32'h8000_0001, 32'h0000_0020,  2'b10, 0);
    req("ror4",     32'h0000_00F1, 32'd4,          2'b11, 0);
    req("oor_ror",  32'h0000_00F1, 32'h0000_0044,  2'b11, 1);
    req("srl31",    32'hFFFF_FFFF, 32'd31,         2'b01, 0);
    req("bp10",     32'hA5A5_0F0F, 32'd3,          2'b00, 10);

    for (int i = 0; i < 40; i++) begin
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      req("rand", $urandom, rs, 2'($urandom), $urandom_range(0, 3));
    end

    // Reset in the middle of a long shift must discard the request
    @(negedge clk);
    in_valid = 1'b1; data = 32'h0000_0003; extShamt = 32'd20; op = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.result", result, 32'd0);
    chk("midrst.range_err", 32'(range_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("midrst.no_result", 32'(bad), 32'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
